mau_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port memory access unit (MAU). It shares the MAU between the instruction-fetch port (read-only) and the data port (load/store), issues exactly one MAU command per transaction, waits for the MAU done strobe, and returns data or an error to the winning requester. Data port has priority, with a streak limit guaranteeing fetch progress.

---
 rtl/mau_arb_pkg.sv | 19 +
 rtl/mau_arb_priority.sv | 45 ++++
 rtl/mau_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mau_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_arb_pkg.sv
// Shared definitions for the MAU arbiter slice.
//   state_t  : sequencer states (idle, command issue, wait for done, response)
//   PORT_*   : identifiers of the two requesters as latched per transaction
//   DATA_W   : address and data width of both requester ports and the MAU
package mau_arb_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mau_arb_priority.sv
// Grant decision between the fetch and data ports, with a data-grant streak
// counter that forces a fetch grant once MAX_DM_STREAK consecutive data
// grants have been given while fetch was waiting.
//   clk, rst_n          : clock, asynchronous active-low reset
//   idle                : sequencer is idle; grants only exist in this state
//   if_valid, dm_valid  : request valids of the two ports
//   grant_if, grant_dm  : one-hot (or none) grant for the current cycle
module mau_arb_priority #(
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic if_valid,
    input  logic dm_valid,
    output logic grant_if,
    output logic grant_dm
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    logic [3:0] streak_q;
    logic       if_forced;

    always_comb begin
        if_forced = if_valid && (streak_q == STREAK_MAX);
        grant_dm  = idle && dm_valid && !if_forced;
        grant_if  = idle && if_valid && !grant_dm;
    end

    // The streak only measures how long fetch has been kept waiting, so any
    // idle cycle without a fetch request resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (idle) begin
            if (!if_valid || grant_if) begin
                streak_q <= '0;
            end else if (grant_dm && (streak_q != STREAK_MAX)) begin
                streak_q <= streak_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mau_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port MAU. One
// transaction at a time: accept (IDLE) -> one-cycle MAU command (ISSUE) ->
// wait for the matching done strobe or a timeout (WAIT) -> one-cycle
// response to the winning port (RESP).
//   if_*   : instruction-fetch port, read-only; ready/valid request, one-cycle
//            response strobe with data and timeout error
//   dm_*   : data port, load/store; same handshake, write responses carry 0
//   mau_*  : command, address and write data to the MAU; read data and
//            read/write done strobes back from it
module mau_arbiter
    import mau_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned MAX_DM_STREAK  = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,

    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic              dm_req_we,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    output logic              dm_rsp_err,

    output logic              mau_mem_read,
    output logic              mau_mem_write,
    output logic [DATA_W-1:0] mau_address,
    output logic [DATA_W-1:0] mau_write_data,
    input  logic [DATA_W-1:0] mau_read_data,
    input  logic              mau_read_done,
    input  logic              mau_write_done
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t            state_q;
    logic              port_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        tmo_q;
    logic              mau_rd_q;
    logic              mau_wr_q;
    logic              if_rsp_valid_q;
    logic [DATA_W-1:0] if_rsp_data_q;
    logic              if_rsp_err_q;
    logic              dm_rsp_valid_q;
    logic [DATA_W-1:0] dm_rsp_data_q;
    logic              dm_rsp_err_q;

    logic idle;
    logic grant_if;
    logic grant_dm;
    logic done_hit;
    logic tmo_hit;

    assign idle = (state_q == ST_IDLE);

    mau_arb_priority #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_priority (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle     (idle),
        .if_valid (if_req_valid),
        .dm_valid (dm_req_valid),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    // Ready is combinational from the grant; it is masked by rst_n so that
    // nothing looks accepted while reset is held.
    assign if_req_ready = grant_if & rst_n;
    assign dm_req_ready = grant_dm & rst_n;

    // Only the done strobe matching the issued command completes it.
    assign done_hit = we_q ? mau_write_done : mau_read_done;
    assign tmo_hit  = (tmo_q == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            port_q         <= PORT_IF;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            tmo_q          <= '0;
            mau_rd_q       <= 1'b0;
            mau_wr_q       <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            if_rsp_err_q   <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            dm_rsp_data_q  <= '0;
            dm_rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_dm) begin
                        port_q   <= PORT_DM;
                        addr_q   <= dm_addr;
                        we_q     <= dm_req_we;
                        wdata_q  <= dm_wdata;
                        mau_rd_q <= !dm_req_we;
                        mau_wr_q <= dm_req_we;
                        state_q  <= ST_ISSUE;
                    end else if (grant_if) begin
                        port_q   <= PORT_IF;
                        addr_q   <= if_addr;
                        we_q     <= 1'b0;
                        wdata_q  <= '0;
                        mau_rd_q <= 1'b1;
                        mau_wr_q <= 1'b0;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mau_rd_q <= 1'b0;
                    mau_wr_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last allowed cycle still wins.
                    if (done_hit || tmo_hit) begin
                        if (port_q == PORT_DM) begin
                            dm_rsp_valid_q <= 1'b1;
                            dm_rsp_data_q  <= (done_hit && !we_q) ? mau_read_data : '0;
                            dm_rsp_err_q   <= !done_hit;
                        end else begin
                            if_rsp_valid_q <= 1'b1;
                            if_rsp_data_q  <= done_hit ? mau_read_data : '0;
                            if_rsp_err_q   <= !done_hit;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    if_rsp_valid_q <= 1'b0;
                    dm_rsp_valid_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mau_mem_read   = mau_rd_q;
    assign mau_mem_write  = mau_wr_q;
    assign mau_address    = addr_q;
    assign mau_write_data = wdata_q;

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign if_rsp_err   = if_rsp_err_q;
    assign dm_rsp_valid = dm_rsp_valid_q;
    assign dm_rsp_data  = dm_rsp_data_q;
    assign dm_rsp_err   = dm_rsp_err_q;

endmodule

// File: tb/tb_mau_arbiter.sv
// Scoreboard bench for mau_arbiter: handshakes push expected responses,
// responses pop and compare; a behavioural MAU stub answers commands.
module tb_mau_arbiter;
    import mau_arb_pkg::*;

    localparam int unsigned TMO  = 15;
    localparam int unsigned MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic        dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid, dm_rsp_err;
    logic [31:0] dm_addr, dm_wdata, dm_rsp_data;
    logic        mau_mem_read, mau_mem_write, mau_read_done, mau_write_done;
    logic [31:0] mau_address, mau_write_data, mau_read_data;

    mau_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_DM_STREAK (MAXS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_we     (dm_req_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_data   (dm_rsp_data),
        .dm_rsp_err    (dm_rsp_err),
        .mau_mem_read  (mau_mem_read),
        .mau_mem_write (mau_mem_write),
        .mau_address   (mau_address),
        .mau_write_data(mau_write_data),
        .mau_read_data (mau_read_data),
        .mau_read_done (mau_read_done),
        .mau_write_done(mau_write_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // MAU stub: mode 0 answers one cycle after the command, mode 1 never
    // answers, mode 2 answers with the wrong done strobe.
    int unsigned mau_mode = 0;
    logic [31:0] mem [0:63];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[4] = 32'hDEADBEEF;
        mau_read_done  = 1'b0;
        mau_write_done = 1'b0;
        mau_read_data  = '0;
        forever begin
            @(posedge clk);
            mau_read_done  <= 1'b0;
            mau_write_done <= 1'b0;
            if (mau_mem_read) begin
                if (mau_mode == 0) begin
                    mau_read_data <= mem[mau_address[7:2]];
                    mau_read_done <= 1'b1;
                end else if (mau_mode == 2) begin
                    mau_write_done <= 1'b1;
                end
            end
            if (mau_mem_write) begin
                if (mau_mode == 0) begin
                    mem[mau_address[7:2]] <= mau_write_data;
                    mau_write_done        <= 1'b1;
                end else if (mau_mode == 2) begin
                    mau_read_done <= 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    logic        glog[$];
    int unsigned gcyc[$];

    // Monitor: samples on the falling edge, mid-cycle.
    initial begin
        logic [31:0] ref_mem [0:63];
        exp_t        e;
        int unsigned n_rd, n_wr;
        logic [31:0] got_d;
        logic        got_e;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        ref_mem[4] = 32'hDEADBEEF;
        n_rd = 0;
        n_wr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                n_rd = 0;
                n_wr = 0;
            end else begin
                if (mau_mem_read || mau_mem_write) begin
                    if (mau_mem_read)  n_rd++;
                    if (mau_mem_write) n_wr++;
                    if (sb.size() == 0) begin
                        check_eq("cmd_unexpected", 64'd1, 64'd0);
                    end else begin
                        check_eq("mau_addr", 64'(mau_address), 64'(sb[0].addr));
                        if (mau_mem_write)
                            check_eq("mau_wdata", 64'(mau_write_data), 64'(sb[0].wdata));
                    end
                end
                if (if_rsp_valid || dm_rsp_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("rsp_unexpected", 64'({if_rsp_valid, dm_rsp_valid}), 64'd0);
                    end else begin
                        e     = sb.pop_front();
                        got_d = e.port ? dm_rsp_data : if_rsp_data;
                        got_e = e.port ? dm_rsp_err  : if_rsp_err;
                        check_eq("rsp_port", 64'({if_rsp_valid, dm_rsp_valid}), e.port ? 64'd1 : 64'd2);
                        check_eq("rsp_data", 64'(got_d), 64'(e.data));
                        check_eq("rsp_err", 64'(got_e), 64'(e.err));
                        check_eq("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                        check_eq("cmd_pulses", 64'({n_rd[7:0], n_wr[7:0]}), e.we ? 64'h0001 : 64'h0100);
                        n_rd = 0;
                        n_wr = 0;
                    end
                end
                if (if_req_valid && dm_req_valid)
                    check_eq("ready_not_both", 64'(if_req_ready & dm_req_ready), 64'd0);
                if ((dm_req_valid && dm_req_ready) || (if_req_valid && if_req_ready)) begin
                    if (dm_req_valid && dm_req_ready) begin
                        e.port  = PORT_DM;
                        e.we    = dm_req_we;
                        e.addr  = dm_addr;
                        e.wdata = dm_wdata;
                    end else begin
                        e.port  = PORT_IF;
                        e.we    = 1'b0;
                        e.addr  = if_addr;
                        e.wdata = '0;
                    end
                    e.acc = cyc;
                    if (mau_mode == 0) begin
                        e.err  = 1'b0;
                        e.lat  = 3;
                        e.data = e.we ? 32'd0 : ref_mem[e.addr[7:2]];
                        if (e.we) ref_mem[e.addr[7:2]] = e.wdata;
                    end else begin
                        e.err  = 1'b1;
                        e.lat  = 3 + TMO;
                        e.data = '0;
                    end
                    sb.push_back(e);
                    glog.push_back(e.port);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    task automatic if_req(input logic [31:0] a);
        int unsigned n = 0;
        if_addr      = a;
        if_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!if_req_ready && n < 200);
        if (!if_req_ready) check_eq("if_ready_wait", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
    endtask

    task automatic dm_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        int unsigned n = 0;
        dm_req_we    = we;
        dm_addr      = a;
        dm_wdata     = d;
        dm_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_req_ready && n < 200);
        if (!dm_req_ready) check_eq("dm_ready_wait", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        dm_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctrl"}, 64'({if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid,
                                      if_rsp_err, dm_rsp_err, mau_mem_read, mau_mem_write}), 64'd0);
        check_eq({tag, "_rsp_data"}, {if_rsp_data, dm_rsp_data}, 64'd0);
        check_eq({tag, "_mau_bus"}, {mau_address, mau_write_data}, 64'd0);
    endtask

    initial begin
        int unsigned g0;
        logic [7:0]  order;
        logic [31:0] a, d;

        rst_n        = 1'b0;
        if_req_valid = 1'b0;
        if_addr      = '0;
        dm_req_valid = 1'b0;
        dm_req_we    = 1'b0;
        dm_addr      = '0;
        dm_wdata     = '0;

        // Reset state, with a fetch request present to show ready is masked.
        repeat (2) @(negedge clk);
        if_req_valid = 1'b1;
        #1;
        check_outputs_zero("reset");
        if_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch read of a preloaded word.
        if_req(32'h10);
        wait_idle();

        // Data write, then read back on the data port.
        dm_req(1'b1, 32'h20, 32'hCAFEF00D);
        dm_req(1'b0, 32'h20, 32'h0);
        wait_idle();

        // Random stores read back through the fetch port.
        for (int i = 0; i < 4; i++) begin
            a = {24'd0, 6'($urandom_range(16, 63)), 2'b00};
            d = $urandom;
            dm_req(1'b1, a, d);
            if_req(a);
        end
        wait_idle();

        // Simultaneous requests: data wins, fetch is accepted 4 cycles later.
        g0 = glog.size();
        fork
            if_req(32'h40);
            dm_req(1'b0, 32'h10, 32'h0);
            begin
                @(negedge clk);
                check_eq("simul_ready", 64'({if_req_ready, dm_req_ready}), 64'd1);
            end
        join
        wait_idle();
        check_eq("simul_grants", 64'(glog.size() - g0), 64'd2);
        if (glog.size() - g0 == 2) begin
            check_eq("simul_order", 64'({glog[g0], glog[g0+1]}), 64'({PORT_DM, PORT_IF}));
            check_eq("simul_gap", 64'(gcyc[g0+1] - gcyc[g0]), 64'd4);
        end

        // Streak limit: continuous data traffic cannot starve fetch.
        g0 = glog.size();
        fork
            repeat (6) dm_req(1'b0, 32'h24, 32'h0);
            repeat (2) if_req(32'h10);
        join
        wait_idle();
        check_eq("streak_grants", 64'(glog.size() - g0), 64'd8);
        if (glog.size() - g0 == 8) begin
            for (int i = 0; i < 8; i++) order[7-i] = glog[g0+i];
            check_eq("streak_order", 64'(order), 64'b1111_0110);
        end

        // Timeout with a silent MAU, then with the wrong done strobe.
        mau_mode = 1;
        dm_req(1'b0, 32'h30, 32'h0);
        wait_idle();
        mau_mode = 2;
        if_req(32'h10);
        wait_idle();
        mau_mode = 1;
        dm_req(1'b1, 32'h34, 32'h1234_5678);
        wait_idle();
        mau_mode = 0;
        if_req(32'h34);
        wait_idle();

        // Reset while waiting on the MAU: everything drops, no response.
        mau_mode = 1;
        dm_req(1'b0, 32'h08, 32'h0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_wait");
        repeat (2) @(negedge clk);
        mau_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_no_rsp", 64'({if_rsp_valid, dm_rsp_valid}), 64'd0);
        @(posedge clk);
        #1;
        dm_req(1'b0, 32'h20, 32'h0);
        wait_idle();
        if_req(32'h10);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
